snow64_instr_cache_assoc: RTL and testbench
===========================================

// Module: snow64_instr_cache_assoc
// PURPOSE
//  Parametrised N-way set-associative instruction cache; successor to the direct-mapped icache.
//  Sits between fetch (req_read side) and the memory arbiter (mem_access side).
//  Adds configurable ways/sets/line width, PLRU replacement and a whole-cache flush.
// PARAMETERS
//  WIDTH__CPU_ADDR      64   byte address width
//  WIDTH__INSTR         32   instruction width; power of 2, >= 8
//  WIDTH__LINE_DATA     256  line width; power-of-2 multiple of WIDTH__INSTR
//  ARR_SIZE__NUM_SETS   32   sets; power of 2, >= 2
//  NUM_WAYS             2    ways per set: 1, 2 or 4
// PORTS
//  clk                         in   1                 clock
//  rst                         in   1                 synchronous, active-high reset
//  in_req_read_req             in   1                 fetch request; sampled only when not busy
//  in_req_read_addr            in   WIDTH__CPU_ADDR   fetch byte address; low log2(INSTR/8) bits ignored
//  in_flush                    in   1                 one-cycle pulse: invalidate all lines
//  in_mem_access_valid         in   1                 line data valid from memory
//  in_mem_access_data          in   WIDTH__LINE_DATA  line data; instr 0 in bits [WIDTH__INSTR-1:0]
//  out_req_read_busy           out  1                 1 = new requests are ignored
//  out_req_read_valid          out  1                 one-cycle pulse: out_req_read_instr valid
//  out_req_read_instr          out  WIDTH__INSTR      fetched instruction
//  out_mem_access_req          out  1                 line fill request; level
//  out_mem_access_addr         out  WIDTH__CPU_ADDR   line-aligned fill address
// BEHAVIOUR
//  - Address split, MSB to LSB: tag | arr_index (log2 SETS) | line_index (log2 LINE/INSTR) | dont_care (log2 INSTR/8).
//  - Reset: all valid bits 0, PLRU state 0, state IDLE, every output 0, flush_pending 0.
//  - FSM IDLE -> LOOKUP. On a hit, LOOKUP -> IDLE. On a miss, LOOKUP -> MEM_WAIT -> FILL -> IDLE.
//  - IDLE: busy=0. A req is captured (addr registered); go to LOOKUP. busy=1 from the next cycle.
//  - LOOKUP: compare the tag in all ways of the set.
//    - Hit: valid=1 with the instr this cycle, so a hit has 1 cycle of latency after capture.
//    - Hit updates PLRU to mark the hit way MRU.
//    - Miss: pick the victim and go to MEM_WAIT.
//  - Victim: the lowest-index invalid way. If all ways are valid, the PLRU way.
//    - NUM_WAYS=1: way 0.
//    - NUM_WAYS=2: 1 LRU bit per set.
//    - NUM_WAYS=4: 3-bit tree per set.
//  - MEM_WAIT: out_mem_access_req=1 and addr={tag,arr_index,0...} are held stable until in_mem_access_valid.
//  - FILL: write the data, tag and valid=1 into the victim. Assert valid with the selected instr. Victim becomes MRU. Go to IDLE.
//    - Miss latency = mem latency + 3 cycles after capture.
//  - out_mem_access_req drops in the cycle after valid is seen. in_mem_access_valid outside MEM_WAIT is ignored.
//  - The requester holds no obligation. The result is never cancelled once captured.
//  - Flush:
//    - In IDLE: all valid bits are cleared at the next edge.
//    - While busy: flush_pending is set. The in-flight access completes and responds normally.
//    - Pending flush: on entry to IDLE all valid bits are cleared; the just-filled line is also invalidated.
//    - A flush and a req in the same IDLE cycle: the flush wins; the req is captured and looks up an empty cache, so it misses.
//  - Reset mid-miss: return to IDLE immediately and drop mem req. A later in_mem_access_valid is ignored.
//  - Same address twice back-to-back: the second request hits the line just filled.
// STRUCTURE
//  - PkgSnow64InstrCache gains a State enum (IDLE, LOOKUP, MEM_WAIT, FILL) and default-width localparams.
//  - Derived widths (tag/index/line_index) are localparams in the module, computed with $clog2.
//  - Tag/valid/data arrays are registers in the module; valid is kept in flops for single-cycle flush.
//  - Sub-module snow64_icache_plru (param NUM_WAYS):
//    - inputs: per-set state, hit/fill way, update strobe;
//    - outputs: victim way, next state.
// TESTING (defaults unless stated)
//  1. Cold miss to 0x1004 -> mem req addr 0x1000. Data supplied 4 cycles later -> valid with instr word 1. Re-read 0x101C -> hit, valid 1 cycle after capture.
//  2. 2-way conflicts: fill A=0x0000, B=0x2000 (set 0). Read A, then fill C=0x4000 -> B is evicted. Read A -> hit; read B -> miss.
//  3. NUM_WAYS=4: fill 4 tags in one set, touch ways 0,2. The 5th fill evicts the way the tree names (way 1); check PLRU bits.
//  4. Flush in IDLE after fills -> every address misses. Flush during MEM_WAIT -> the response is still delivered; the next read of the same addr misses.
//  5. Reset asserted in MEM_WAIT, then a stray in_mem_access_valid -> outputs stay 0, no line becomes valid, next req behaves as a cold miss.
//  6. Req held high while busy for 10 cycles -> exactly one response, no duplicate mem reqs. A mem stall of 20 cycles keeps addr stable.

Source files
------------

// File: rtl/snow64_instr_cache_assoc_pkg.sv
// Shared types and default sizes for the set-associative instruction cache.
// Includes helpers that derive way-index and PLRU-state widths.
package PkgSnow64InstrCache;

    localparam int DEF_WIDTH__CPU_ADDR   = 64;
    localparam int DEF_WIDTH__INSTR      = 32;
    localparam int DEF_WIDTH__LINE_DATA  = 256;
    localparam int DEF_ARR_SIZE__NUM_SETS = 32;
    localparam int DEF_NUM_WAYS          = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MEM_WAIT,
        FILL
    } State;

    function automatic int calc_way_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_plru_w(input int n);
        return (n == 4) ? 3 : 1;
    endfunction

endpackage

// File: rtl/snow64_instr_cache_assoc_plru.sv
// Pseudo-LRU helper: names the replacement way for one set and computes
// that set's next state when a way is touched.
module snow64_icache_plru
    import PkgSnow64InstrCache::*;
#(
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    localparam int WAY_W    = calc_way_w(NUM_WAYS),
    localparam int PLRU_W   = calc_plru_w(NUM_WAYS)
) (
    input  logic [PLRU_W-1:0] i_state,
    input  logic [WAY_W-1:0]  i_way,
    input  logic              i_update,
    output logic [WAY_W-1:0]  o_victim,
    output logic [PLRU_W-1:0] o_next
);

    logic [PLRU_W-1:0] w_touched;

    if (NUM_WAYS == 4) begin : g_tree
        // Tree bits: [0] root (0 = left pair), [1] ways 0/1, [2] ways 2/3.
        always_comb begin
            o_victim = i_state[0] ? {1'b1, i_state[2]} : {1'b0, i_state[1]};
            w_touched = i_state;
            w_touched[0] = ~i_way[1];
            if (i_way[1]) begin
                w_touched[2] = ~i_way[0];
            end else begin
                w_touched[1] = ~i_way[0];
            end
        end
    end else if (NUM_WAYS == 2) begin : g_bit
        // The single bit holds the least recently used way.
        always_comb begin
            o_victim  = i_state[0];
            w_touched = ~i_way;
        end
    end else begin : g_direct
        logic w_unused_way;
        assign w_unused_way = ^i_way;
        // Only one way exists, so there is nothing to track.
        always_comb begin
            o_victim  = '0;
            w_touched = i_state;
        end
    end

    assign o_next = i_update ? w_touched : i_state;

endmodule

// File: rtl/snow64_instr_cache_assoc.sv
// N-way set-associative instruction cache between fetch and the memory
// arbiter, with PLRU replacement and a single-cycle whole-cache flush.
module snow64_instr_cache_assoc
    import PkgSnow64InstrCache::*;
#(
    parameter int WIDTH__CPU_ADDR    = DEF_WIDTH__CPU_ADDR,
    parameter int WIDTH__INSTR       = DEF_WIDTH__INSTR,
    parameter int WIDTH__LINE_DATA   = DEF_WIDTH__LINE_DATA,
    parameter int ARR_SIZE__NUM_SETS = DEF_ARR_SIZE__NUM_SETS,
    parameter int NUM_WAYS           = DEF_NUM_WAYS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_req_read_req,
    input  logic [WIDTH__CPU_ADDR-1:0]  in_req_read_addr,
    input  logic                        in_flush,
    input  logic                        in_mem_access_valid,
    input  logic [WIDTH__LINE_DATA-1:0] in_mem_access_data,
    output logic                        out_req_read_busy,
    output logic                        out_req_read_valid,
    output logic [WIDTH__INSTR-1:0]     out_req_read_instr,
    output logic                        out_mem_access_req,
    output logic [WIDTH__CPU_ADDR-1:0]  out_mem_access_addr
);

    localparam int DC_W   = $clog2(WIDTH__INSTR / 8);
    localparam int LI_W   = $clog2(WIDTH__LINE_DATA / WIDTH__INSTR);
    localparam int IDX_W  = $clog2(ARR_SIZE__NUM_SETS);
    localparam int TAG_W  = WIDTH__CPU_ADDR - IDX_W - LI_W - DC_W;
    localparam int IW_LOG = $clog2(WIDTH__INSTR);
    localparam int WAY_W  = calc_way_w(NUM_WAYS);
    localparam int PLRU_W = calc_plru_w(NUM_WAYS);

    State                  r_state;
    logic                  r_busy;
    logic                  r_out_valid;
    logic [WIDTH__INSTR-1:0] r_out_instr;
    logic                  r_mem_req;
    logic [WIDTH__CPU_ADDR-1:0] r_mem_addr;
    logic                  r_flush_pending;
    logic [TAG_W-1:0]      r_tag_q;
    logic [IDX_W-1:0]      r_set;
    logic [LI_W-1:0]       r_li;
    logic                  r_hit;
    logic [WAY_W-1:0]      r_hit_way;
    logic [WAY_W-1:0]      r_victim;

    logic [ARR_SIZE__NUM_SETS-1:0][NUM_WAYS-1:0] r_vld;
    logic [ARR_SIZE__NUM_SETS-1:0][PLRU_W-1:0]   r_plru;
    logic [TAG_W-1:0]            r_tag  [ARR_SIZE__NUM_SETS][NUM_WAYS];
    logic [WIDTH__LINE_DATA-1:0] r_data [ARR_SIZE__NUM_SETS][NUM_WAYS];

    logic [TAG_W-1:0]        w_in_tag;
    logic [IDX_W-1:0]        w_in_set;
    logic [LI_W-1:0]         w_in_li;
    logic [NUM_WAYS-1:0]     w_way_hit;
    logic [WIDTH__INSTR-1:0] w_way_instr [NUM_WAYS];
    logic [WAY_W-1:0]        w_hit_way;
    logic [WIDTH__INSTR-1:0] w_hit_instr;
    logic                    w_lookup_hit;
    logic [WAY_W-1:0]        w_victim;
    logic [WAY_W-1:0]        w_plru_victim;
    logic [WAY_W-1:0]        w_plru_way;
    logic                    w_plru_upd;
    logic [PLRU_W-1:0]       w_plru_next;
    logic                    w_to_idle;
    logic                    w_flush_now;
    logic                    w_unused_addr;

    assign w_in_tag = in_req_read_addr[WIDTH__CPU_ADDR-1 -: TAG_W];
    assign w_in_set = in_req_read_addr[DC_W+LI_W +: IDX_W];
    assign w_in_li  = in_req_read_addr[DC_W +: LI_W];
    assign w_unused_addr = ^in_req_read_addr[DC_W-1:0];

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        assign w_way_hit[g] = r_vld[w_in_set][g]
            && (r_tag[w_in_set][g] == w_in_tag);
        assign w_way_instr[g] = WIDTH__INSTR'(
            r_data[w_in_set][g] >> {w_in_li, {IW_LOG{1'b0}}});
    end

    // Tag compare on the incoming address so a hit answers in LOOKUP.
    always_comb begin
        w_hit_way   = '0;
        w_hit_instr = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_way_hit[w]) begin
                w_hit_way   = WAY_W'(w);
                w_hit_instr = w_way_instr[w];
            end
        end
    end

    // A flush in the capture cycle empties the cache, so it must miss.
    assign w_lookup_hit = (|w_way_hit) && !in_flush;

    // Lowest invalid way first, otherwise whatever PLRU names.
    always_comb begin
        w_victim = w_plru_victim;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_vld[r_set][w]) begin
                w_victim = WAY_W'(w);
            end
        end
    end

    assign w_plru_upd = ((r_state == LOOKUP) && r_hit) || (r_state == FILL);
    assign w_plru_way = (r_state == FILL) ? r_victim : r_hit_way;

    snow64_icache_plru #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .i_state  (r_plru[r_set]),
        .i_way    (w_plru_way),
        .i_update (w_plru_upd),
        .o_victim (w_plru_victim),
        .o_next   (w_plru_next)
    );

    assign w_to_idle = ((r_state == LOOKUP) && r_hit) || (r_state == FILL);
    assign w_flush_now = (in_flush && (r_state == IDLE))
        || (w_to_idle && (r_flush_pending || in_flush));

    // Control FSM, valid/PLRU state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_instr     <= '0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
            r_flush_pending <= 1'b0;
            r_tag_q         <= '0;
            r_set           <= '0;
            r_li            <= '0;
            r_hit           <= 1'b0;
            r_hit_way       <= '0;
            r_victim        <= '0;
            r_vld           <= '0;
            r_plru          <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_plru_upd) begin
                r_plru[r_set] <= w_plru_next;
            end
            unique case (r_state)
                IDLE: begin
                    if (in_req_read_req) begin
                        r_tag_q     <= w_in_tag;
                        r_set       <= w_in_set;
                        r_li        <= w_in_li;
                        r_hit       <= w_lookup_hit;
                        r_hit_way   <= w_hit_way;
                        r_out_valid <= w_lookup_hit;
                        if (w_lookup_hit) begin
                            r_out_instr <= w_hit_instr;
                        end
                        r_busy  <= 1'b1;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (r_hit) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_victim   <= w_victim;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_tag_q, r_set, {(LI_W+DC_W){1'b0}}};
                        r_state    <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (in_mem_access_valid) begin
                        r_mem_req             <= 1'b0;
                        r_vld[r_set][r_victim] <= 1'b1;
                        r_out_valid           <= 1'b1;
                        r_out_instr <= WIDTH__INSTR'(
                            in_mem_access_data >> {r_li, {IW_LOG{1'b0}}});
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_flush_now) begin
                r_vld <= '0;
            end
            if (w_to_idle) begin
                r_flush_pending <= 1'b0;
            end else if (in_flush && (r_state != IDLE)) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    // Line data and tags are written once memory answers a miss.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == MEM_WAIT) && in_mem_access_valid) begin
            r_data[r_set][r_victim] <= in_mem_access_data;
            r_tag[r_set][r_victim]  <= r_tag_q;
        end
    end

    assign out_req_read_busy   = r_busy;
    assign out_req_read_valid  = r_out_valid;
    assign out_req_read_instr  = r_out_instr;
    assign out_mem_access_req  = r_mem_req;
    assign out_mem_access_addr = r_mem_addr;

endmodule

// File: tb/tb_snow64_instr_cache_assoc.sv
// Directed bench for the set-associative icache: a 2-way instance for
// the main paths and a 4-way instance for tree-PLRU eviction.
module tb_snow64_instr_cache_assoc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst    [2];
    logic         req    [2];
    logic [63:0]  addr   [2];
    logic         flush  [2];
    logic         mvalid [2];
    logic [255:0] mdata  [2];
    logic         busy   [2];
    logic         ovalid [2];
    logic [31:0]  oinstr [2];
    logic         mreq   [2];
    logic [63:0]  maddr  [2];

    int checks = 0;
    int errors = 0;

    snow64_instr_cache_assoc u_dut2 (
        .clk                 (clk),
        .rst                 (rst[0]),
        .in_req_read_req     (req[0]),
        .in_req_read_addr    (addr[0]),
        .in_flush            (flush[0]),
        .in_mem_access_valid (mvalid[0]),
        .in_mem_access_data  (mdata[0]),
        .out_req_read_busy   (busy[0]),
        .out_req_read_valid  (ovalid[0]),
        .out_req_read_instr  (oinstr[0]),
        .out_mem_access_req  (mreq[0]),
        .out_mem_access_addr (maddr[0])
    );

    snow64_instr_cache_assoc #(
        .NUM_WAYS (4)
    ) u_dut4 (
        .clk                 (clk),
        .rst                 (rst[1]),
        .in_req_read_req     (req[1]),
        .in_req_read_addr    (addr[1]),
        .in_flush            (flush[1]),
        .in_mem_access_valid (mvalid[1]),
        .in_mem_access_data  (mdata[1]),
        .out_req_read_busy   (busy[1]),
        .out_req_read_valid  (ovalid[1]),
        .out_req_read_instr  (oinstr[1]),
        .out_mem_access_req  (mreq[1]),
        .out_mem_access_addr (maddr[1])
    );

    function automatic logic [31:0] word_of(input logic [63:0] a);
        logic [63:0] line;
        line = a & ~64'h1F;
        return {4'hC, line[27:0]} | 32'(a[4:2]);
    endfunction

    function automatic logic [255:0] line_data(input logic [63:0] line);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) begin
            d[i*32 +: 32] = {4'hC, line[27:0]} | 32'(i);
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_flush(input int d);
        @(negedge clk);
        flush[d] = 1'b1;
        @(negedge clk);
        flush[d] = 1'b0;
    endtask

    task automatic rd(input int d, input logic [63:0] a, input bit exp_hit,
                      input int lat, input int hold, input int flush_k,
                      input bit fl_req, input string tag);
        logic [63:0] line;
        logic [31:0] ins;
        int n, k, rises;
        bit got, bad_addr;
        logic prev_req;
        line = a & ~64'h1F;
        @(negedge clk);
        req[d] = 1'b1;
        addr[d] = a;
        flush[d] = fl_req;
        n = 0; k = 0; rises = 0; got = 0; bad_addr = 0;
        prev_req = 1'b0; ins = '0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            req[d] = (n < hold);
            flush[d] = 1'b0;
            mvalid[d] = 1'b0;
            if (mreq[d] && !prev_req) rises++;
            prev_req = mreq[d];
            if (ovalid[d]) begin
                got = 1;
                ins = oinstr[d];
            end else if (mreq[d]) begin
                if (maddr[d] !== line) bad_addr = 1;
                if (k == flush_k) flush[d] = 1'b1;
                if (k == lat) begin
                    mvalid[d] = 1'b1;
                    mdata[d] = line_data(line);
                end
                k++;
            end
        end
        req[d] = 1'b0;
        chk({tag, ":resp"}, 64'(got), 64'd1);
        chk({tag, ":instr"}, 64'(ins), 64'(word_of(a)));
        chk({tag, ":lat"}, 64'(n), exp_hit ? 64'd1 : 64'(lat + 3));
        chk({tag, ":memreqs"}, 64'(rises), exp_hit ? 64'd0 : 64'd1);
        chk({tag, ":addr"}, 64'(bad_addr), 64'd0);
        chk({tag, ":reqdrop"}, 64'(mreq[d]), 64'd0);
        @(negedge clk);
        chk({tag, ":pulse"}, 64'(ovalid[d]), 64'd0);
        chk({tag, ":idle"}, 64'(busy[d]), 64'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; addr[d] = '0; flush[d] = 1'b0;
            mvalid[d] = 1'b0; mdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("rst:busy", 64'(busy[0]), 64'd0);
        chk("rst:valid", 64'(ovalid[0]), 64'd0);
        chk("rst:instr", 64'(oinstr[0]), 64'd0);
        chk("rst:mreq", 64'(mreq[0]), 64'd0);
        chk("rst:maddr", maddr[0], 64'd0);

        rd(0, 64'h1004, 0, 4, 0, -1, 0, "cold");
        rd(0, 64'h101C, 1, 0, 0, -1, 0, "rehit");

        rd(0, 64'h0000, 0, 1, 0, -1, 0, "fillA");
        rd(0, 64'h2000, 0, 1, 0, -1, 0, "fillB");
        rd(0, 64'h0008, 1, 0, 0, -1, 0, "touchA");
        rd(0, 64'h4000, 0, 1, 0, -1, 0, "fillC");
        rd(0, 64'h0004, 1, 0, 0, -1, 0, "hitA");
        rd(0, 64'h4010, 1, 0, 0, -1, 0, "hitC");
        rd(0, 64'h2004, 0, 1, 0, -1, 0, "evictB");

        pulse_flush(0);
        rd(0, 64'h0000, 0, 1, 0, -1, 0, "flA");
        rd(0, 64'h2000, 0, 2, 0, -1, 0, "flB");
        rd(0, 64'h3000, 0, 3, 0, 1, 0, "flushmw");
        rd(0, 64'h0000, 0, 1, 0, -1, 0, "flpendA");
        rd(0, 64'h3000, 0, 1, 0, -1, 0, "afterfl");
        rd(0, 64'h300C, 1, 0, 0, -1, 0, "refillhit");
        rd(0, 64'h3008, 0, 1, 0, -1, 1, "flreq");

        rd(0, 64'h7004, 0, 20, 10, -1, 0, "hold");

        @(negedge clk);
        req[0] = 1'b1;
        addr[0] = 64'h5000;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        chk("rstmw:mreq", 64'(mreq[0]), 64'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("rstmw:busy", 64'(busy[0]), 64'd0);
        chk("rstmw:mreqdrop", 64'(mreq[0]), 64'd0);
        chk("rstmw:maddr", maddr[0], 64'd0);
        mvalid[0] = 1'b1;
        mdata[0] = line_data(64'h5000);
        @(negedge clk);
        mvalid[0] = 1'b0;
        @(negedge clk);
        chk("stray:valid", 64'(ovalid[0]), 64'd0);
        chk("stray:instr", 64'(oinstr[0]), 64'd0);
        chk("stray:mreq", 64'(mreq[0]), 64'd0);
        chk("stray:busy", 64'(busy[0]), 64'd0);
        chk("stray:vld", 64'(u_dut2.r_vld), 64'd0);
        rd(0, 64'h5000, 0, 2, 0, -1, 0, "postrst");

        rd(1, 64'h0000, 0, 1, 0, -1, 0, "w4f0");
        rd(1, 64'h0400, 0, 1, 0, -1, 0, "w4f1");
        rd(1, 64'h0800, 0, 1, 0, -1, 0, "w4f2");
        rd(1, 64'h0C00, 0, 1, 0, -1, 0, "w4f3");
        chk("w4:plru_fill", 64'(u_dut4.r_plru[0]), 64'd0);
        rd(1, 64'h0004, 1, 0, 0, -1, 0, "w4t0");
        rd(1, 64'h0808, 1, 0, 0, -1, 0, "w4t2");
        chk("w4:plru_touch", 64'(u_dut4.r_plru[0]), 64'h6);
        rd(1, 64'h1000, 0, 1, 0, -1, 0, "w4f4");
        chk("w4:plru_evict", 64'(u_dut4.r_plru[0]), 64'h5);
        rd(1, 64'h0000, 1, 0, 0, -1, 0, "w4h0");
        rd(1, 64'h0800, 1, 0, 0, -1, 0, "w4h2");
        rd(1, 64'h0C00, 1, 0, 0, -1, 0, "w4h3");
        rd(1, 64'h1000, 1, 0, 0, -1, 0, "w4h4");
        rd(1, 64'h0400, 0, 1, 0, -1, 0, "w4gone1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
